frame_seq_ctrl: RTL and testbench

Sequences the per-frame payload length calculator in the transmit path. Accepts one transfer request (total payload bytes), loads the calculator, issues one frame descriptor per frame to the frame generator, and steps the calculator after each frame completes. Enforces a programmable inter-frame gap and reports transfer completion. Sits between the traffic-pattern control logic and the frame generator/length calculator pair.

---
 rtl/frame_seq_pkg.sv | 22 ++
 rtl/ifg_timer.sv | 38 +++
 rtl/frame_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_frame_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg
//   Shared types and constants for the frame sequencer.
//   - state_e           : sequencer states (IDLE, ISSUE, WAIT_DONE, GAP)
//   - DEFAULT_LEN_W     : default byte-count width
//   - len_t             : byte-count type at the default width
//   - MAX_FRAME_PAYLOAD : largest frame payload the calculator emits
//                         (used by benches and calculator models)
package frame_seq_pkg;

  localparam int DEFAULT_LEN_W     = 16;
  localparam int MAX_FRAME_PAYLOAD = 1500;

  typedef logic [DEFAULT_LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

endpackage

// File: rtl/ifg_timer.sv
// ifg_timer
//   Loadable down-counter that times the inter-frame gap.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     start_i     : load the counter with IFG_CYCLES
//     clear_i     : force the counter to zero (abort)
//     expired_o   : high during the final gap cycle
//   Parameter IFG_CYCLES sets the gap length; the counter is
//   $clog2(IFG_CYCLES+1) bits wide, never narrower than 1.
module ifg_timer #(
  parameter int IFG_CYCLES = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CNT_W = (IFG_CYCLES < 1) ? 1 : $clog2(IFG_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CNT_W'(IFG_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Loaded in the frm_done cycle, so the count reaches 1 in the
  // IFG_CYCLES-th gap cycle; the sequencer leaves GAP on that edge.
  assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl
//   Sequences the per-frame payload length calculator: accepts one
//   transfer request, loads the calculator, issues one descriptor per
//   frame to the frame generator, steps the calculator after each
//   frame and inserts IFG_CYCLES idle cycles after every frame.
//   Ports:
//     clk, rst_n                  : clock, synchronous active-low reset
//     req_valid/req_ready/req_bytes: transfer request handshake
//     req_done                    : pulse, transfer finished normally
//     abort / abort_done          : cancel transfer / pulse, abort taken
//     calc_load/calc_step/calc_bytes: calculator control
//     calc_len/calc_last          : calculator outputs (forwarded only)
//     frm_valid/frm_ready/frm_len/frm_last: frame descriptor handshake
//     frm_done                    : pulse, generator finished the frame
//     stat_frames/stat_bytes      : only with FRAME_SEQ_STATS_EN defined
//     dbg_state_o                 : current sequencer state
//   Optional feature macro: FRAME_SEQ_STATS_EN.
//
//   Handshakes: a transfer happens in a cycle where valid and ready are
//   both high. Once raised, frm_valid holds with stable frm_len/frm_last
//   until that cycle; only an abort may drop it early (and abort also
//   masks frm_valid in its own cycle so no descriptor slips through).
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int LEN_W      = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_bytes,
  output logic             req_done,
  input  logic             abort,
  output logic             abort_done,
  output logic             calc_load,
  output logic             calc_step,
  output logic [LEN_W-1:0] calc_bytes,
  input  logic [LEN_W-1:0] calc_len,
  input  logic             calc_last,
  output logic             frm_valid,
  input  logic             frm_ready,
  output logic [LEN_W-1:0] frm_len,
  output logic             frm_last,
  input  logic             frm_done,
`ifdef FRAME_SEQ_STATS_EN
  output logic [31:0]      stat_frames,
  output logic [31:0]      stat_bytes,
`endif
  output state_e           dbg_state_o
);

  state_e state_q;
  logic   last_q;
  logic   req_done_q;
  logic   abort_done_q;
  logic   abort_take;
  logic   frame_end;
  logic   gap_expired;

  // abort is ignored while idle
  assign abort_take = abort && (state_q != IDLE);
  assign frame_end  = (state_q == WAIT_DONE) && frm_done && !abort_take;

  assign req_ready  = (state_q == IDLE);
  assign calc_load  = (state_q == IDLE) && req_valid && (req_bytes != '0);
  assign calc_bytes = req_bytes;
  assign calc_step  = frame_end && !last_q;
  assign frm_valid  = (state_q == ISSUE) && !abort;
  assign frm_len    = calc_len;
  assign frm_last   = calc_last;
  assign req_done   = req_done_q;
  assign abort_done = abort_done_q;
  assign dbg_state_o = state_q;

  ifg_timer #(
    .IFG_CYCLES (IFG_CYCLES)
  ) u_ifg_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (frame_end),
    .clear_i   (abort_take),
    .expired_o (gap_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      req_done_q   <= 1'b0;
      abort_done_q <= 1'b0;
    end else begin
      req_done_q   <= 1'b0;
      abort_done_q <= 1'b0;
      if (abort_take) begin
        state_q      <= IDLE;
        abort_done_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid) begin
              // A zero-byte transfer completes without touching the calculator
              if (req_bytes != '0) state_q <= ISSUE;
              else                 req_done_q <= 1'b1;
            end
          end
          ISSUE: begin
            if (frm_ready) begin
              last_q  <= calc_last;
              state_q <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (frm_done) begin
              req_done_q <= last_q;
              if (IFG_CYCLES == 0) state_q <= last_q ? IDLE : ISSUE;
              else                 state_q <= GAP;
            end
          end
          GAP: begin
            if (gap_expired) state_q <= last_q ? IDLE : ISSUE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef FRAME_SEQ_STATS_EN
  // Counts accepted descriptors; survives abort, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_bytes  <= '0;
    end else if (frm_valid && frm_ready) begin
      stat_frames <= stat_frames + 32'd1;
      stat_bytes  <= stat_bytes + 32'(frm_len);
    end
  end
`endif

endmodule

// File: tb/tb_frame_seq_ctrl.sv
module tb_frame_seq_ctrl;
  import frame_seq_pkg::*;

  localparam int LEN_W    = 16;
  localparam int IFG      = 12;
  localparam int MIN_TAIL = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (IFG_CYCLES = 12) ----------------
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [LEN_W-1:0] req_bytes = '0;
  logic             req_done;
  logic             abort = 1'b0;
  logic             abort_done;
  logic             calc_load;
  logic             calc_step;
  logic [LEN_W-1:0] calc_bytes;
  logic [LEN_W-1:0] calc_len;
  logic             calc_last;
  logic             frm_valid;
  logic             frm_ready = 1'b0;
  logic [LEN_W-1:0] frm_len;
  logic             frm_last;
  logic             frm_done = 1'b0;
  state_e           dbg_state;
`ifdef FRAME_SEQ_STATS_EN
  logic [31:0]      stat_frames;
  logic [31:0]      stat_bytes;
`endif

  frame_seq_ctrl #(.IFG_CYCLES(IFG), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_bytes(req_bytes),
    .req_done(req_done), .abort(abort), .abort_done(abort_done),
    .calc_load(calc_load), .calc_step(calc_step), .calc_bytes(calc_bytes),
    .calc_len(calc_len), .calc_last(calc_last),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_len(frm_len),
    .frm_last(frm_last), .frm_done(frm_done),
`ifdef FRAME_SEQ_STATS_EN
    .stat_frames(stat_frames), .stat_bytes(stat_bytes),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- second DUT (IFG_CYCLES = 0) ----------------
  logic             req_valid0 = 1'b0;
  logic             req_ready0;
  logic [LEN_W-1:0] req_bytes0 = '0;
  logic             req_done0;
  logic             abort0 = 1'b0;
  logic             abort_done0;
  logic             calc_load0;
  logic             calc_step0;
  logic [LEN_W-1:0] calc_bytes0;
  logic [LEN_W-1:0] calc_len0 = 16'd1500;
  logic             calc_last0 = 1'b0;
  logic             frm_valid0;
  logic             frm_ready0 = 1'b0;
  logic [LEN_W-1:0] frm_len0;
  logic             frm_last0;
  logic             frm_done0 = 1'b0;
  state_e           dbg_state0;
`ifdef FRAME_SEQ_STATS_EN
  logic [31:0]      stat_frames0;
  logic [31:0]      stat_bytes0;
`endif

  frame_seq_ctrl #(.IFG_CYCLES(0), .LEN_W(LEN_W)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_bytes(req_bytes0),
    .req_done(req_done0), .abort(abort0), .abort_done(abort_done0),
    .calc_load(calc_load0), .calc_step(calc_step0), .calc_bytes(calc_bytes0),
    .calc_len(calc_len0), .calc_last(calc_last0),
    .frm_valid(frm_valid0), .frm_ready(frm_ready0), .frm_len(frm_len0),
    .frm_last(frm_last0), .frm_done(frm_done0),
`ifdef FRAME_SEQ_STATS_EN
    .stat_frames(stat_frames0), .stat_bytes(stat_bytes0),
`endif
    .dbg_state_o(dbg_state0)
  );

  // ---------------- calculator stub ----------------
  // Full 1500-byte frames; a tail shorter than MIN_TAIL is avoided by
  // splitting the last two frames evenly.
  function automatic logic [LEN_W:0] calc_fn(input logic [LEN_W-1:0] r);
    if (int'(r) <= MAX_FRAME_PAYLOAD)
      return {1'b1, r};
    else if (int'(r) - MAX_FRAME_PAYLOAD < MIN_TAIL)
      return {1'b0, LEN_W'((int'(r) + 1) / 2)};
    else
      return {1'b0, LEN_W'(MAX_FRAME_PAYLOAD)};
  endfunction

  logic [LEN_W-1:0] rem_q;
  always @(posedge clk) begin
    if (!rst_n)         rem_q <= '0;
    else if (calc_load) rem_q <= calc_bytes;
    else if (calc_step) rem_q <= rem_q - calc_len;
  end
  assign {calc_last, calc_len} = calc_fn(rem_q);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int load_cnt = 0;
  int hs_cnt   = 0;
  logic [LEN_W:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && frm_valid && frm_ready) begin
      logic [LEN_W:0] e;
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("sb_queue_nonempty", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_frm_len", frm_len, e[LEN_W-1:0]);
        check_eq("sb_frm_last", frm_last, e[LEN_W]);
      end
    end
    if (calc_step) step_cnt++;
    if (calc_load) load_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frm_valid && n < 100);
    check_eq("frm_valid_seen", frm_valid, 1);
  endtask

  task automatic do_transfer(input int bytes, input int n_frames);
    step_cnt = 0;
    tick(); req_valid = 1'b1; req_bytes = LEN_W'(bytes);
    @(negedge clk);
    check_eq("accept_ready", req_ready, 1);
    check_eq("accept_calc_load", calc_load, 1);
    check_eq("accept_calc_bytes", calc_bytes, bytes);
    tick(); req_valid = 1'b0;
    @(negedge clk);
    check_eq("valid_at_t1", frm_valid, 1);
    check_eq("busy_ready_low", req_ready, 0);
    for (int f = 0; f < n_frames; f++) begin
      logic last;
      last = (f == n_frames - 1);
      wait_valid();
      tick(); @(negedge clk);
      check_eq("valid_hold", frm_valid, 1);
      tick(); frm_ready = 1'b1;
      @(negedge clk);
      tick(); frm_ready = 1'b0;
      @(negedge clk);
      check_eq("valid_drop", frm_valid, 0);
      tick(); frm_done = 1'b1;
      @(negedge clk);
      check_eq("calc_step_on_done", calc_step, !last);
      tick(); frm_done = 1'b0;
      for (int k = 1; k <= IFG; k++) begin
        @(negedge clk);
        if (last) check_eq("gap_ready_low", req_ready, 0);
        else      check_eq("gap_valid_low", frm_valid, 0);
        if (k == 1) check_eq("req_done_d1", req_done, last);
        if (k == 2) check_eq("req_done_d2", req_done, 0);
        tick();
      end
      @(negedge clk);
      if (last) check_eq("ready_after_gap", req_ready, 1);
      else      check_eq("valid_after_gap", frm_valid, 1);
    end
    tick(); tick();
    check_eq("calc_step_count", step_cnt, n_frames - 1);
    check_eq("sb_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_frm_valid", frm_valid, 0);
    check_eq("rst_req_done", req_done, 0);
    check_eq("rst_abort_done", abort_done, 0);
    check_eq("rst_state", dbg_state, IDLE);

    // IFG_CYCLES = 0: next descriptor right after frm_done
    tick(); req_valid0 = 1'b1; req_bytes0 = 16'd3000;
    @(negedge clk); check_eq("ifg0_calc_load", calc_load0, 1);
    tick(); req_valid0 = 1'b0;
    @(negedge clk); check_eq("ifg0_valid_t1", frm_valid0, 1);
    check_eq("ifg0_frm_len", frm_len0, 1500);
    tick(); frm_ready0 = 1'b1;
    tick(); frm_ready0 = 1'b0;
    @(negedge clk); check_eq("ifg0_valid_drop", frm_valid0, 0);
    tick(); frm_done0 = 1'b1;
    @(negedge clk); check_eq("ifg0_calc_step", calc_step0, 1);
    tick(); frm_done0 = 1'b0;
    @(negedge clk); check_eq("ifg0_valid_d1", frm_valid0, 1);
`ifdef FRAME_SEQ_STATS_EN
    check_eq("ifg0_stat_frames", stat_frames0, 1);
`endif
    tick(); abort0 = 1'b1;
    tick(); abort0 = 1'b0;
    @(negedge clk);
    check_eq("ifg0_abort_done", abort_done0, 1);
    check_eq("ifg0_abort_ready", req_ready0, 1);

    // single frame
    exp_q.push_back({1'b1, 16'd1000});
    do_transfer(1000, 1);
    // two full frames
    exp_q.push_back({1'b0, 16'd1500});
    exp_q.push_back({1'b1, 16'd1500});
    do_transfer(3000, 2);
    // short-tail split
    exp_q.push_back({1'b0, 16'd775});
    exp_q.push_back({1'b1, 16'd775});
    do_transfer(1550, 2);
    // full frame plus tail
    exp_q.push_back({1'b0, 16'd1500});
    exp_q.push_back({1'b1, 16'd101});
    do_transfer(1601, 2);

    // zero-byte request
    load_cnt = 0;
    tick(); req_valid = 1'b1; req_bytes = '0;
    @(negedge clk);
    check_eq("zero_no_load", calc_load, 0);
    check_eq("zero_done_early", req_done, 0);
    tick(); req_valid = 1'b0;
    @(negedge clk);
    check_eq("zero_req_done", req_done, 1);
    check_eq("zero_no_valid", frm_valid, 0);
    check_eq("zero_ready", req_ready, 1);
    tick(); @(negedge clk);
    check_eq("zero_done_pulse", req_done, 0);
    check_eq("zero_load_count", load_cnt, 0);

    // abort in IDLE is ignored
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    @(negedge clk);
    check_eq("idle_abort_ignored", abort_done, 0);

    // abort together with frm_done in WAIT_DONE
    step_cnt = 0;
    exp_q.push_back({1'b0, 16'd1500});
    tick(); req_valid = 1'b1; req_bytes = 16'd3000;
    tick(); req_valid = 1'b0;
    wait_valid();
    tick(); frm_ready = 1'b1;
    tick(); frm_ready = 1'b0;
    tick(); frm_done = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_eq("abort_no_step", calc_step, 0);
    tick(); frm_done = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("abort_done_pulse", abort_done, 1);
    check_eq("abort_no_req_done", req_done, 0);
    check_eq("abort_ready", req_ready, 1);
    check_eq("abort_no_valid", frm_valid, 0);
`ifdef FRAME_SEQ_STATS_EN
    check_eq("stat_frames_kept", stat_frames, 8);
    check_eq("stat_bytes_kept", stat_bytes, 8651);
`endif
    tick(); @(negedge clk);
    check_eq("abort_done_width", abort_done, 0);
    check_eq("abort_step_count", step_cnt, 0);
    check_eq("handshake_total", hs_cnt, 8);

    // reset in the middle of a transfer
    tick(); req_valid = 1'b1; req_bytes = 16'd1000;
    tick(); req_valid = 1'b0;
    wait_valid();
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", req_ready, 1);
    check_eq("midrst_valid", frm_valid, 0);
    check_eq("midrst_req_done", req_done, 0);
    check_eq("midrst_abort_done", abort_done, 0);
`ifdef FRAME_SEQ_STATS_EN
    check_eq("midrst_stat_frames", stat_frames, 0);
`endif

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
